// File: rtl/seq_div4.sv
// Sequential restoring divider: unsigned A / B, one quotient bit per clock.
// Start/done handshake; divide-by-zero is flagged one cycle after the request.
module seq_div4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    cnt;
  logic             dz_pending;

  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH:0]   trial;

  // The partial remainder never exceeds WIDTH-1 significant bits before a shift,
  // so dropping rem's MSB in the shift loses nothing.
  always_comb begin
    rem_shift = {rem[WIDTH-2:0], quo[WIDTH-1]};
    trial     = {1'b0, rem_shift} - {1'b0, divisor};
    rem_next  = rem_shift;
    quo_next  = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      cnt         <= '0;
      dz_pending  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The dividend of a pending divide-by-zero still sits in quo.
          if (dz_pending) begin
            done        <= 1'b1;
            div_by_zero <= 1'b1;
            Q           <= '1;
            R           <= quo;
            dz_pending  <= 1'b0;
          end
          if (start) begin
            quo     <= A;
            divisor <= B;
            rem     <= '0;
            cnt     <= CW'(WIDTH);
            if (B != '0) begin
              state <= CALC;
              busy  <= 1'b1;
            end else begin
              dz_pending <= 1'b1;
            end
          end
        end
        CALC: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            Q           <= quo_next;
            R           <= rem_next;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div4.sv
// Scoreboard bench for seq_div4: stimulus pushes expected results computed with
// plain / and %, a negedge monitor pops and compares each done pulse.
module tb_seq_div4;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;

  typedef struct {
    int q;
    int r;
    int dz;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   tests;
  int   fails;

  seq_div4 #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .A(A),
    .B(B),
    .busy(busy),
    .done(done),
    .Q(Q),
    .R(R),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: ordinary integer division; divide-by-zero returns all ones and A.
  task automatic applyStimulus(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q  = (1 << WIDTH) - 1;
      e.r  = a;
      e.dz = 1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 0;
    end
    e.cyc = cyc + 1 + ((b == 0) ? 1 : WIDTH);
    start = 1'b1;
    A     = WIDTH'(a);
    B     = WIDTH'(b);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("idle_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) checkOutput("done_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("Q", int'(Q), e.q);
        checkOutput("R", int'(R), e.r);
        checkOutput("div_by_zero", int'(div_by_zero), e.dz);
        checkOutput("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cnt;
    int busy_seen;
    cyc   = 0;
    tests = 0;
    fails = 0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_Q", int'(Q), 0);
    checkOutput("reset_R", int'(R), 0);
    checkOutput("reset_dz", int'(div_by_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 13/4 with busy high for exactly WIDTH cycles
    applyStimulus(13, 4);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", busy_cnt, WIDTH);
    checkOutput("sb_after_13_4", sb.size(), 0);

    applyStimulus(15, 1);
    waitIdle();
    applyStimulus(3, 9);
    waitIdle();

    // Divide by zero: busy must stay low
    applyStimulus(7, 0);
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy) busy_seen = 1;
      @(negedge clk);
    end
    checkOutput("dz_busy", busy_seen, 0);
    waitIdle();

    // Start while busy is ignored
    applyStimulus(13, 4);
    start = 1'b1;
    A     = WIDTH'(2);
    B     = WIDTH'(1);
    @(negedge clk);
    start = 1'b0;
    waitIdle();

    // Back-to-back: second start issued in the done cycle
    applyStimulus(9, 2);
    waitDone();
    applyStimulus(8, 3);
    waitIdle();
    @(negedge clk);

    // Reset in the middle of a division
    applyStimulus(13, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_done", int'(done), 0);
    checkOutput("midreset_Q", int'(Q), 0);
    checkOutput("midreset_R", int'(R), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(6, 3);
    waitIdle();

    // Randomized operands and idle gaps, including zero-gap back-to-back
    for (int n = 0; n < 60; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      applyStimulus($urandom_range(0, 15), $urandom_range(0, 15));
      waitDone();
    end
    waitIdle();

    // Every operand pair
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(a, b);
        waitIdle();
      end
    end

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
